// File: rtl/irq_scheduler.sv
// irq_scheduler
//   Interrupt scheduler feeding the CSR machine-external interrupt inputs.
//   Each source is synchronised and latched as pending (edge or level
//   mode per EDGE_MASK). A round-robin arbiter picks one enabled pending
//   source and presents it one-hot on o_MEI. The claim/complete handshake
//   keeps at most one source presented or in service at any time.
// Ports
//   i_CLK, i_RSTn   clock, async active-low reset
//   i_SRC           raw interrupt lines (async to i_CLK)
//   i_SRC_EN        per-source enable
//   i_CLAIM         core took the trap for the presented source (pulse)
//   i_COMPLETE      core finished servicing, mret (pulse)
//   o_MEI           one-hot request, zero when nothing is presented
//   o_CLAIM_ID      index of the source in service, valid while o_ACTIVE
//   o_ACTIVE        a claimed source is in service
//   o_PENDING       pending vector before the enable mask

// Per-source front end: synchroniser plus pending latch.
module irq_src_lane #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE        = 1'b0
) (
  input  logic i_CLK,
  input  logic i_RSTn,
  input  logic src,
  input  logic clr,
  output logic pend
);
  // SYNC_STAGES synchroniser flops plus one more so that edge and level
  // sources share the same registered copy of the line.
  logic [SYNC_STAGES:0] sync_pipe;
  logic                 line_q;
  logic                 rise;

  assign rise = sync_pipe[SYNC_STAGES] & ~line_q;

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      sync_pipe <= '0;
      line_q    <= 1'b0;
      pend      <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-1:0], src};
      line_q    <= sync_pipe[SYNC_STAGES];
      if (EDGE) begin
        // a fresh edge beats a claim landing in the same cycle
        if (rise)     pend <= 1'b1;
        else if (clr) pend <= 1'b0;
      end else begin
        pend <= sync_pipe[SYNC_STAGES];
      end
    end
  end
endmodule

module irq_scheduler #(
  parameter int                N_SRC       = 6,
  parameter logic [N_SRC-1:0]  EDGE_MASK   = '0,
  parameter int                SYNC_STAGES = 2,
  parameter int                IDW         = 3
) (
  input  logic             i_CLK,
  input  logic             i_RSTn,
  input  logic [N_SRC-1:0] i_SRC,
  input  logic [N_SRC-1:0] i_SRC_EN,
  input  logic             i_CLAIM,
  input  logic             i_COMPLETE,
  output logic [N_SRC-1:0] o_MEI,
  output logic [IDW-1:0]   o_CLAIM_ID,
  output logic             o_ACTIVE,
  output logic [N_SRC-1:0] o_PENDING
);
  typedef enum logic [1:0] {S_IDLE, S_ARB, S_PRESENT, S_SERVICE} state_t;

  localparam logic [N_SRC-1:0] ONE = N_SRC'(1);

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   win_q;
  logic [N_SRC-1:0] req;
  logic             clm_acc;
  logic [IDW-1:0]   arb_win;
  logic             arb_hit;
  logic [IDW-1:0]   cand;

  assign req     = o_PENDING & i_SRC_EN;
  assign clm_acc = (state == S_PRESENT) && i_CLAIM;

  for (genvar g = 0; g < N_SRC; g++) begin : g_lane
    irq_src_lane #(
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE        (EDGE_MASK[g])
    ) u_lane (
      .i_CLK  (i_CLK),
      .i_RSTn (i_RSTn),
      .src    (i_SRC[g]),
      .clr    (clm_acc && (win_q == IDW'(g))),
      .pend   (o_PENDING[g])
    );
  end

  // Round robin: scan rr_ptr+1, rr_ptr+2, ... wrapping at N_SRC. The
  // wrap is done by subtraction so nothing ever exceeds IDW bits.
  always_comb begin
    arb_win = '0;
    arb_hit = 1'b0;
    cand    = '0;
    for (int off = 1; off <= N_SRC; off++) begin
      if (rr_ptr >= IDW'(N_SRC - off)) cand = rr_ptr - IDW'(N_SRC - off);
      else                             cand = rr_ptr + IDW'(off);
      if (!arb_hit && req[cand]) begin
        arb_hit = 1'b1;
        arb_win = cand;
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state      <= S_IDLE;
      rr_ptr     <= IDW'(N_SRC - 1);
      win_q      <= '0;
      o_MEI      <= '0;
      o_ACTIVE   <= 1'b0;
      o_CLAIM_ID <= '0;
    end else begin
      case (state)
        S_IDLE: if (|req) state <= S_ARB;
        S_ARB: begin
          if (!arb_hit) begin
            state <= S_IDLE;
          end else begin
            win_q <= arb_win;
            o_MEI <= ONE << arb_win;
            state <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          // claim takes priority over a request dropping in the same cycle
          if (i_CLAIM) begin
            o_MEI      <= '0;
            o_ACTIVE   <= 1'b1;
            o_CLAIM_ID <= win_q;
            rr_ptr     <= win_q;
            state      <= S_SERVICE;
          end else if (!req[win_q]) begin
            o_MEI <= '0;
            state <= S_IDLE;
          end
        end
        S_SERVICE: begin
          if (i_COMPLETE) begin
            o_ACTIVE <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_irq_scheduler.sv
module tb_irq_scheduler;
  localparam int N  = 6;
  localparam int S  = 2;
  localparam logic [N-1:0] EM = 6'b000011;  // src0, src1 edge; rest level

  logic         i_CLK = 1'b0;
  logic         i_RSTn;
  logic [N-1:0] i_SRC, i_SRC_EN;
  logic         i_CLAIM, i_COMPLETE;
  logic [N-1:0] o_MEI, o_PENDING;
  logic [2:0]   o_CLAIM_ID;
  logic         o_ACTIVE;

  irq_scheduler #(.N_SRC(N), .EDGE_MASK(EM), .SYNC_STAGES(S), .IDW(3)) dut (
    .i_CLK(i_CLK), .i_RSTn(i_RSTn), .i_SRC(i_SRC), .i_SRC_EN(i_SRC_EN),
    .i_CLAIM(i_CLAIM), .i_COMPLETE(i_COMPLETE), .o_MEI(o_MEI),
    .o_CLAIM_ID(o_CLAIM_ID), .o_ACTIVE(o_ACTIVE), .o_PENDING(o_PENDING)
  );

  always #5 i_CLK = ~i_CLK;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge i_CLK);
  endtask

  // ---------------- behavioural reference model ----------------
  // phase: 0 idle, 1 arbitrate, 2 presented, 3 in service
  bit [N-1:0] m_pend, m_mei;
  bit         m_act;
  int         m_cid, m_win, m_rr, m_ph;
  bit [N-1:0] m_q[$];   // raw samples, newest first

  always @(posedge i_CLK or negedge i_RSTn) begin
    bit [N-1:0] req, npend, line, prv, em;
    bit acc, hit;
    int idx;
    if (!i_RSTn) begin
      m_pend = '0; m_mei = '0; m_act = 1'b0; m_cid = 0; m_win = 0;
      m_rr = N - 1; m_ph = 0;
      m_q.delete();
      for (int j = 0; j < S + 2; j++) m_q.push_back('0);
    end else begin
      em   = EM;
      req  = m_pend & i_SRC_EN;
      acc  = (m_ph == 2) && i_CLAIM;
      line = m_q[S];
      prv  = m_q[S+1];
      for (int i = 0; i < N; i++) begin
        if (em[i]) npend[i] = (line[i] && !prv[i]) ? 1'b1 : ((acc && i == m_win) ? 1'b0 : m_pend[i]);
        else       npend[i] = line[i];
      end
      case (m_ph)
        0: if (req != 0) m_ph = 1;
        1: begin
          if (req == 0) m_ph = 0;
          else begin
            hit = 1'b0;
            for (int off = 1; off <= N; off++) begin
              idx = (m_rr + off) % N;
              if (!hit && req[idx]) begin hit = 1'b1; m_win = idx; end
            end
            m_mei = '0;
            m_mei[m_win] = 1'b1;
            m_ph = 2;
          end
        end
        2: begin
          if (i_CLAIM) begin
            m_ph = 3; m_mei = '0; m_act = 1'b1; m_cid = m_win; m_rr = m_win;
          end else if (!req[m_win]) begin
            m_ph = 0; m_mei = '0;
          end
        end
        default: if (i_COMPLETE) begin m_ph = 0; m_act = 1'b0; end
      endcase
      m_pend = npend;
      m_q.push_front(i_SRC);
      void'(m_q.pop_back());
    end
  end

  always @(negedge i_CLK) begin
    logic [31:0] a, e;
    if (chk_on) begin
      a = {13'd0, o_MEI, o_ACTIVE, o_PENDING, (o_ACTIVE ? o_CLAIM_ID : 3'd0), 1'b0};
      e = {13'd0, m_mei, m_act, m_pend, (m_act ? 3'(m_cid) : 3'd0), 1'b0};
      chk("model", a, e);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run still going at %0t, expected to have finished", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic [N-1:0] src;
    logic         clm;
    logic         cmp;
    int           wt;
    logic [N-1:0] mei;
    logic         act;
    int           cid;
  } vec_t;
  vec_t tv[9];
  int   rb;

  initial begin
    // src2 + src4 level: 2 first, then 4, then back to 2
    tv[0] = '{6'b010100, 0, 0, 6,  6'b000100, 0, 0};
    tv[1] = '{6'b010100, 1, 0, 1,  6'b000000, 1, 2};
    tv[2] = '{6'b010100, 0, 1, 1,  6'b000000, 0, 0};
    tv[3] = '{6'b010100, 0, 0, 2,  6'b010000, 0, 0};
    tv[4] = '{6'b010100, 1, 0, 1,  6'b000000, 1, 4};
    tv[5] = '{6'b010100, 0, 1, 3,  6'b000100, 0, 0};
    tv[6] = '{6'b010100, 1, 0, 1,  6'b000000, 1, 2};
    tv[7] = '{6'b000000, 0, 1, 1,  6'b000000, 0, 0};
    tv[8] = '{6'b000000, 0, 0, 10, 6'b000000, 0, 0};

    i_RSTn = 1'b0; i_SRC = '0; i_SRC_EN = '1; i_CLAIM = 1'b0; i_COMPLETE = 1'b0;
    nclk(2);
    chk("rst_mei", o_MEI, 0);
    chk("rst_act", o_ACTIVE, 0);
    chk("rst_cid", o_CLAIM_ID, 0);
    chk("rst_pend", o_PENDING, 0);
    i_RSTn = 1'b1;
    chk_on = 1'b1;
    nclk(1);

    for (int i = 0; i < 9; i++) begin
      i_SRC = tv[i].src; i_CLAIM = tv[i].clm; i_COMPLETE = tv[i].cmp;
      nclk(1);
      i_CLAIM = 1'b0; i_COMPLETE = 1'b0;
      nclk(tv[i].wt - 1);
      chk($sformatf("tbl%0d_mei", i), o_MEI, tv[i].mei);
      chk($sformatf("tbl%0d_act", i), o_ACTIVE, tv[i].act);
      if (tv[i].act) chk($sformatf("tbl%0d_cid", i), o_CLAIM_ID, tv[i].cid);
    end

    // edge src1, single-cycle pulse: presented exactly 5 edges later
    i_SRC = 6'b000010; nclk(1); i_SRC = '0;
    for (int n = 1; n <= 5; n++) begin
      chk($sformatf("e1_lat%0d", n), o_MEI, 0);
      if (n == 3) chk("e1_pend_early", o_PENDING[1], 0);
      if (n == 4) chk("e1_pend_set", o_PENDING[1], 1);
      nclk(1);
    end
    chk("e1_mei", o_MEI, 6'b000010);
    nclk(2);
    chk("e1_hold", o_MEI, 6'b000010);
    chk("e1_pend_hold", o_PENDING[1], 1);
    i_CLAIM = 1'b1; nclk(1); i_CLAIM = 1'b0;
    chk("e1_act", o_ACTIVE, 1);
    chk("e1_cid", o_CLAIM_ID, 1);
    chk("e1_pend_clr", o_PENDING[1], 0);
    i_COMPLETE = 1'b1; nclk(1); i_COMPLETE = 1'b0;
    nclk(4);
    chk("e1_idle", {o_MEI, o_ACTIVE}, 0);

    // level src3 dropped while presented, never claimed
    i_SRC = 6'b001000; nclk(6);
    chk("l3_mei", o_MEI, 6'b001000);
    i_SRC = '0; nclk(4);
    chk("l3_still", o_MEI, 6'b001000);
    nclk(1);
    chk("l3_drop", o_MEI, 0);
    nclk(5);
    chk("l3_noact", {o_MEI, o_ACTIVE}, 0);

    // edge src0: second edge lands on the claim cycle and survives
    i_SRC = 6'b000001; nclk(1); i_SRC = '0;
    nclk(3);
    i_SRC = 6'b000001; nclk(1); i_SRC = '0;
    nclk(1);
    chk("e0_mei", o_MEI, 6'b000001);
    nclk(1);
    i_CLAIM = 1'b1; nclk(1); i_CLAIM = 1'b0;
    chk("e0_act", o_ACTIVE, 1);
    chk("e0_cid", o_CLAIM_ID, 0);
    chk("e0_pend_kept", o_PENDING[0], 1);
    i_COMPLETE = 1'b1; nclk(1); i_COMPLETE = 1'b0;
    nclk(2);
    chk("e0_again", o_MEI, 6'b000001);
    i_CLAIM = 1'b1; nclk(1); i_CLAIM = 1'b0;
    chk("e0_pend_clr", o_PENDING[0], 0);
    i_COMPLETE = 1'b1; nclk(1); i_COMPLETE = 1'b0;
    nclk(3);
    chk("e0_idle", {o_MEI, o_ACTIVE}, 0);

    // src2 disabled: never presented; stray claim/complete ignored
    i_SRC_EN = 6'b111011; i_SRC = 6'b000100;
    for (int n = 0; n < 10; n++) begin
      nclk(1);
      chk($sformatf("en_mask%0d", n), o_MEI, 0);
    end
    i_COMPLETE = 1'b1; nclk(1); i_COMPLETE = 1'b0;
    chk("stray_cmp", {o_MEI, o_ACTIVE}, 0);
    i_CLAIM = 1'b1; nclk(1); i_CLAIM = 1'b0;
    chk("stray_clm", {o_MEI, o_ACTIVE}, 0);
    i_SRC_EN = '1; nclk(2);
    chk("en_restore", o_MEI, 6'b000100);
    i_CLAIM = 1'b1; nclk(1); i_CLAIM = 1'b0;
    i_SRC = '0;
    i_COMPLETE = 1'b1; nclk(1); i_COMPLETE = 1'b0;
    nclk(10);

    // async reset while servicing src5
    i_SRC = 6'b100000; nclk(6);
    chk("r5_mei", o_MEI, 6'b100000);
    i_CLAIM = 1'b1; nclk(1); i_CLAIM = 1'b0;
    chk("r5_cid", o_CLAIM_ID, 5);
    chk("r5_act", o_ACTIVE, 1);
    #2 i_RSTn = 1'b0;
    i_SRC = 6'b100001;
    #1;
    chk("ar_mei", o_MEI, 0);
    chk("ar_act", o_ACTIVE, 0);
    chk("ar_cid", o_CLAIM_ID, 0);
    chk("ar_pend", o_PENDING, 0);
    nclk(2);
    i_RSTn = 1'b1;
    nclk(6);
    chk("ar_first", o_MEI, 6'b000001);
    i_CLAIM = 1'b1; nclk(1); i_CLAIM = 1'b0;
    chk("ar_cid0", o_CLAIM_ID, 0);
    i_COMPLETE = 1'b1; nclk(1); i_COMPLETE = 1'b0;
    nclk(2);
    chk("ar_next", o_MEI, 6'b100000);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) i_SRC[b] = ~i_SRC[b];
      if ($urandom_range(0, 15) == 0) begin
        rb = $urandom_range(0, N - 1);
        i_SRC_EN[rb] = ~i_SRC_EN[rb];
      end
      if ($urandom_range(0, 31) == 0) i_SRC_EN = '1;
      i_CLAIM    = ($urandom_range(0, 3) == 0);
      i_COMPLETE = ($urandom_range(0, 3) == 0);
      nclk(1);
    end
    i_CLAIM = 1'b0; i_COMPLETE = 1'b0;
    nclk(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
